// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must hold WIDTH-1 without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Purely combinational one-bit full adder; the sequencer owns all state
// around it.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic co
);

    assign sum = a ^ b ^ cin;
    assign co  = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: accepts two WIDTH-bit operands, adds them LSB first
// through one full-adder cell over WIDTH cycles, and returns {co,sum}.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             cell_sum;
    logic             cell_co;

    full_adder_cell u_cell (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry_q),
        .sum (cell_sum),
        .co  (cell_co)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign res_nxt  = {cell_sum, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last_bit)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // All handshake outputs are pure state decodes, so no input reaches
    // an output combinationally.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN:  busy     = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            co      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        res_sh  <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_sh  <= res_nxt;
                    carry_q <= cell_co;
                    cnt     <= cnt + CNT_W'(1);
                    // The final bit goes straight into the output register
                    // so the result is ready the cycle DONE is entered.
                    if (last_bit) begin
                        sum <= res_nxt;
                        co  <= cell_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
